robot_nav_ctrl: RTL
===================

ROBOT_NAV_CTRL -- requirements
Module: robot_nav_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 2, consecutive samples a raw sensor must hold a new level before the filtered value changes (range 1..255).
REQ-002 Parameter TURN_CYCLES, default 3, cycles spent rotating toward the followed wall after losing it (range 1..255).
REQ-003 Parameter ROT_LIMIT, default 8, max consecutive rotate-away cycles before declaring stuck (range 1..255).
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 front_sensor  input  1  raw obstacle-ahead sensor, 1 = blocked.
REQ-007 left_sensor  input  1  raw wall-on-left sensor, 1 = wall present.
REQ-008 right_sensor  input  1  raw wall-on-right sensor, 1 = wall present.
REQ-009 follow_right  input  1  mode: 0 = left-hand wall following, 1 = right-hand.
REQ-010 clear_stuck  input  1  single-cycle request to leave STUCK.
REQ-011 front  output  1  drive forward command.
REQ-012 turn  output  1  rotate-in-place command.
REQ-013 turn_dir  output  1  rotation direction, 0 = left, 1 = right; 0 when turn = 0.
REQ-014 stuck  output  1  high while in STUCK.
REQ-015 state  output  3  current state encoding, for debug.

Function
REQ-016 Each raw sensor SHALL pass through a debouncer: filtered value takes raw value at the edge where raw has differed from filtered for DEBOUNCE consecutive sampled edges; any sample equal to filtered clears the count.
REQ-017 A raw change first sampled at edge k SHALL update filtered at edge k+DEBOUNCE-1 and state at edge k+DEBOUNCE.
REQ-018 Wall signal w = filtered right if mode_q = 1 else filtered left; f = filtered front.
REQ-019 mode_q SHALL load follow_right on every edge while in IDLE or SEARCH and hold in all other states.
REQ-020 Outputs SHALL be Moore, decoded from state only: IDLE 0/0/0; SEARCH, FOLLOW front=1 turn=0; ROT_AWAY turn=1 turn_dir=~mode_q; ROT_TOWARD turn=1 turn_dir=mode_q; STUCK front=0 turn=0 stuck=1.
REQ-021 IDLE -> SEARCH unconditionally on the first edge after rst deasserts.
REQ-022 SEARCH: f=1 -> ROT_AWAY; else w=1 -> FOLLOW; else stay.
REQ-023 FOLLOW: f=1 -> ROT_AWAY; else w=0 -> ROT_TOWARD; else stay; f has priority when both events coincide.
REQ-024 ROT_AWAY: counter increments each cycle; f=0 -> FOLLOW if w=1 else SEARCH; else counter reaching ROT_LIMIT -> STUCK; f=0 wins over limit in the same cycle.
REQ-025 ROT_TOWARD: f=1 -> ROT_AWAY (priority); else after exactly TURN_CYCLES cycles in state -> SEARCH.
REQ-026 STUCK: clear_stuck=1 -> SEARCH; else stay; sensors ignored.
REQ-027 Single shared cycle counter, 8 bits, SHALL clear on every state change and never wrap (saturates at 255).
REQ-028 Unused state encodings SHALL transition to IDLE on the next edge.

Reset
REQ-029 rst high SHALL immediately force state=IDLE, counter=0, all filtered sensors=0, debounce counts=0, mode_q=0; outputs front=0 turn=0 turn_dir=0 stuck=0 state=IDLE.
REQ-030 Reset asserted mid-rotation or in STUCK SHALL abort without completing the turn; recovery follows REQ-021.

Structure
REQ-031 State encodings (IDLE=0, SEARCH=1, FOLLOW=2, ROT_AWAY=3, ROT_TOWARD=4, STUCK=5) and direction constants (DIR_LEFT=0, DIR_RIGHT=1) SHALL live in shared package robot_nav_pkg.
REQ-032 Debouncer SHALL be a sub-module sensor_debounce (parameter DEBOUNCE, ports clk, rst, raw, filt), instantiated three times.
REQ-033 Counter width SHALL derive from the 255 parameter ceiling; no other arithmetic is required.

Verification (DEBOUNCE=2, TURN_CYCLES=3, ROT_LIMIT=8)
REQ-034 Reset release, all sensors 0 -> IDLE one cycle, then SEARCH with front=1 turn=0 indefinitely.
REQ-035 follow_right=0, left_sensor=1 from edge k -> FOLLOW at edge k+2; left_sensor then 0 -> ROT_TOWARD with turn_dir=0 for 3 cycles, then SEARCH.
REQ-036 front_sensor 1-cycle glitch -> no state change; front_sensor held 1 in FOLLOW -> ROT_AWAY turn_dir=1 at edge k+2.
REQ-037 front_sensor held 1 -> ROT_AWAY for 8 cycles, then STUCK stuck=1; clear_stuck pulse -> SEARCH next edge.
REQ-038 follow_right=1, right_sensor=1 -> FOLLOW; front_sensor=1 -> ROT_AWAY turn_dir=0; toggling follow_right during rotation -> turn_dir unchanged.
REQ-039 rst asserted during ROT_TOWARD between edges -> outputs zero immediately, IDLE held until release.

Source files
------------

// File: rtl/robot_nav_pkg.sv
// rtl/robot_nav_pkg.sv - shared state encodings, direction constants and counter helpers
package robot_nav_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEARCH     = 3'd1,
    ST_FOLLOW     = 3'd2,
    ST_ROT_AWAY   = 3'd3,
    ST_ROT_TOWARD = 3'd4,
    ST_STUCK      = 3'd5
  } nav_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Every cycle-count parameter is capped at 255, so one 8-bit counter covers them all.
  localparam int PARAM_MAX = 255;
  localparam int CNT_W     = $clog2(PARAM_MAX + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(PARAM_MAX)) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - raw sensor filter: follows raw after DEBOUNCE consecutive differing samples
module sensor_debounce
  import robot_nav_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   run_len;

  assign run_len = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (raw != filt_q) begin
      if (run_len >= (CNT_W+1)'(DEBOUNCE)) begin
        filt_d = raw;
      end else begin
        cnt_d = run_len[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/robot_nav_ctrl.sv
// rtl/robot_nav_ctrl.sv - wall-following navigation FSM with debounced sensors and stuck detection
module robot_nav_ctrl
  import robot_nav_pkg::*;
#(
  parameter int DEBOUNCE    = 2,
  parameter int TURN_CYCLES = 3,
  parameter int ROT_LIMIT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       front_sensor,
  input  logic       left_sensor,
  input  logic       right_sensor,
  input  logic       follow_right,
  input  logic       clear_stuck,
  output logic       front,
  output logic       turn,
  output logic       turn_dir,
  output logic       stuck,
  output logic [2:0] state
);

  logic f_filt, l_filt, r_filt;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_front (.clk(clk), .rst(rst), .raw(front_sensor), .filt(f_filt));
  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_left  (.clk(clk), .rst(rst), .raw(left_sensor),  .filt(l_filt));
  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_right (.clk(clk), .rst(rst), .raw(right_sensor), .filt(r_filt));

  logic [2:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cycles_in_state;
  logic             wall;

  assign wall            = mode_q ? r_filt : l_filt;
  assign cycles_in_state = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        mode_d  = follow_right;
        state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        mode_d = follow_right;
        if (f_filt)    state_d = ST_ROT_AWAY;
        else if (wall) state_d = ST_FOLLOW;
      end
      ST_FOLLOW: begin
        if (f_filt)     state_d = ST_ROT_AWAY;
        else if (!wall) state_d = ST_ROT_TOWARD;
      end
      ST_ROT_AWAY: begin
        // Clearing the obstacle beats hitting the rotation limit on the same edge.
        if (!f_filt) state_d = wall ? ST_FOLLOW : ST_SEARCH;
        else if (cycles_in_state >= (CNT_W+1)'(ROT_LIMIT)) state_d = ST_STUCK;
      end
      ST_ROT_TOWARD: begin
        if (f_filt) state_d = ST_ROT_AWAY;
        else if (cycles_in_state >= (CNT_W+1)'(TURN_CYCLES)) state_d = ST_SEARCH;
      end
      ST_STUCK: begin
        if (clear_stuck) state_d = ST_SEARCH;
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : sat_inc(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    front    = 1'b0;
    turn     = 1'b0;
    turn_dir = DIR_LEFT;
    stuck    = 1'b0;
    case (state_q)
      ST_SEARCH, ST_FOLLOW: front = 1'b1;
      ST_ROT_AWAY: begin
        turn     = 1'b1;
        turn_dir = mode_q ? DIR_LEFT : DIR_RIGHT;
      end
      ST_ROT_TOWARD: begin
        turn     = 1'b1;
        turn_dir = mode_q ? DIR_RIGHT : DIR_LEFT;
      end
      ST_STUCK: stuck = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
